// File: rtl/clk_div_sync_pkg.sv
// rtl/clk_div_sync_pkg.sv - shared state encodings and defaults for the synchronous clock divider
package clk_div_sync_pkg;

  // Divider control states; encodings are shared with the PHY control logic
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  // Five stages give clk_32f/2 down to clk_32f/32, matching the legacy ripple chain
  localparam int DIV_STAGES_DEF = 5;

endpackage

// File: rtl/clk_div_sync.sv
// rtl/clk_div_sync.sv - single-counter power-of-two clock divider with strobes, glitch-free select and lock
module clk_div_sync
  import clk_div_sync_pkg::*;
#(
  parameter int DIV_STAGES = DIV_STAGES_DEF,
  parameter int SEL_W      = (DIV_STAGES > 1) ? $clog2(DIV_STAGES) : 1
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  input  logic                  en,
  input  logic [SEL_W-1:0]      div_sel,
  output logic [DIV_STAGES-1:0] clk_div,
  output logic [DIV_STAGES-1:0] rise_stb,
  output logic                  clk_sel,
  output logic [SEL_W-1:0]      sel_cur,
  output logic                  locked
);

  // Highest legal select index; larger requests are pinned here
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(DIV_STAGES - 1);

  state_t                  state;
  state_t                  state_next;
  logic [DIV_STAGES-1:0]   cnt;
  logic [DIV_STAGES-1:0]   cnt_next;
  logic [SEL_W-1:0]        sel_lim;
  logic [SEL_W-1:0]        sel_next;
  logic                    wrap;
  logic                    locked_next;

  // Every divided clock is a bit of one register, so all outputs switch on the same edge
  assign clk_div = cnt;

  // Clamp the requested select index into the range of existing outputs
  always_comb begin
    sel_lim = div_sel;
    if (div_sel > SEL_MAX) begin
      sel_lim = SEL_MAX;
    end
  end

  // Next-state, counter advance, select reload and lock tracking
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wrap       = (state != IDLE) && (&cnt);
    case (state)
      IDLE: begin
        if (en) begin
          state_next = RUN;
          cnt_next   = DIV_STAGES'(1);
        end
      end
      RUN: begin
        cnt_next = cnt + DIV_STAGES'(1);
        if (!en) begin
          state_next = STOP;
        end
      end
      STOP: begin
        // Keep counting so the current period completes and outputs rest low
        cnt_next = cnt + DIV_STAGES'(1);
        if (en) begin
          state_next = RUN;
        end else if (wrap) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    // All outputs are low right after a wrap, so switching the select there cannot glitch
    sel_next    = ((state == IDLE) || wrap) ? sel_lim : sel_cur;
    locked_next = (state_next == RUN) && (locked || ((state == RUN) && wrap));
  end

  // State register
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counter and registered outputs, so no output has a combinational path
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      rise_stb <= '0;
      clk_sel  <= 1'b0;
      sel_cur  <= '0;
      locked   <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      rise_stb <= cnt_next & ~cnt;
      clk_sel  <= cnt_next[sel_next];
      sel_cur  <= sel_next;
      locked   <= locked_next;
    end
  end

endmodule

// File: tb/tb_clk_div_sync.sv
// tb/tb_clk_div_sync.sv - directed scoreboard bench for clk_div_sync
module tb_clk_div_sync;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] div_sel;
  logic [4:0] clk_div;
  logic [4:0] rise_stb;
  logic       clk_sel;
  logic [2:0] sel_cur;
  logic       locked;

  clk_div_sync #(.DIV_STAGES(5)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .en      (en),
    .div_sel (div_sel),
    .clk_div (clk_div),
    .rise_stb(rise_stb),
    .clk_sel (clk_sel),
    .sel_cur (sel_cur),
    .locked  (locked)
  );

  // 10 ns fast clock
  always #5 clk_32f = ~clk_32f;

  typedef struct {
    string      tag;
    int         kind;
    logic [7:0] exp;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  string      phase;
  logic [4:0] c;
  logic [4:0] p;
  logic       l;
  logic [2:0] s;

  function automatic logic [7:0] obs(input int kind);
    case (kind)
      0:       return {3'b0, clk_div};
      1:       return {3'b0, rise_stb};
      2:       return {7'b0, clk_sel};
      3:       return {5'b0, sel_cur};
      default: return {7'b0, locked};
    endcase
  endfunction

  task automatic push(input string name, input int kind, input logic [7:0] v);
    exp_t e;
    e.tag  = $sformatf("%s_%s", phase, name);
    e.kind = kind;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic push_all();
    push("clk_div",  0, {3'b0, c});
    push("rise_stb", 1, {3'b0, c & ~p});
    push("clk_sel",  2, {7'b0, c[s]});
    push("sel_cur",  3, {5'b0, s});
    push("locked",   4, {7'b0, l});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (obs(e.kind) === e.exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs(e.kind), e.exp);
      end
    end
  endtask

  // Expectation for the state right after the next rising edge
  task automatic step();
    push_all();
    @(posedge clk_32f);
    #1;
    drain();
  endtask

  // Advance the expected counter edge by edge until it reaches target
  task automatic run_until(input logic [4:0] target, input logic lock_on_wrap, input logic [2:0] sel_on_wrap);
    do begin
      p = c;
      c = c + 5'd1;
      if (c == 5'd0) begin
        if (lock_on_wrap) l = 1'b1;
        s = sel_on_wrap;
      end
      step();
    end while (c != target);
  endtask

  initial begin
    reset   = 1'b0;
    en      = 1'b1;
    div_sel = 3'd0;
    c = '0; p = '0; l = 1'b0; s = '0;

    phase = "reset";
    repeat (3) @(posedge clk_32f);
    #1;
    push_all();
    drain();

    phase = "freerun";
    @(negedge clk_32f);
    reset = 1'b1;
    run_until(5'd0, 1'b1, 3'd0);
    run_until(5'd7, 1'b1, 3'd0);

    phase = "selswitch";
    div_sel = 3'd2;
    run_until(5'd0, 1'b1, 3'd2);
    run_until(5'd3, 1'b1, 3'd2);
    phase = "selclamp";
    div_sel = 3'd7;
    run_until(5'd0, 1'b1, 3'd4);
    run_until(5'd5, 1'b1, 3'd4);

    phase = "stop";
    en = 1'b0;
    l  = 1'b0;
    run_until(5'd0, 1'b0, 3'd4);
    phase = "idle";
    p = c;
    step();
    step();
    div_sel = 3'd1;
    s = 3'd1;
    step();

    phase = "restart";
    en = 1'b1;
    run_until(5'd0, 1'b1, 3'd1);
    run_until(5'd10, 1'b1, 3'd1);
    phase = "abort";
    en = 1'b0;
    l  = 1'b0;
    run_until(5'd20, 1'b0, 3'd1);
    en = 1'b1;
    run_until(5'd0, 1'b1, 3'd1);

    phase = "wrapstop";
    run_until(5'd31, 1'b1, 3'd1);
    en = 1'b0;
    l  = 1'b0;
    run_until(5'd0, 1'b0, 3'd1);
    run_until(5'd0, 1'b0, 3'd1);
    p = c;
    step();

    phase = "asyncrst";
    en = 1'b1;
    run_until(5'd0, 1'b1, 3'd1);
    run_until(5'd13, 1'b1, 3'd1);
    #2;
    reset = 1'b0;
    #1;
    c = '0; p = '0; l = 1'b0; s = '0;
    push_all();
    drain();
    @(negedge clk_32f);
    reset = 1'b1;
    s = 3'd1;
    run_until(5'd3, 1'b1, 3'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
